// File: rtl/regdump_uart_tx.sv
// Register-dump UART 8N1 transmitter: walks reg_select 0..NREGS-1, sends each 32-bit value MSB byte first, LSB bit first.
// Define REGDUMP_CSUM_EN to append one XOR-of-all-bytes checksum frame before done.
`timescale 1ns/1ps
module regdump_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NREGS        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] regval,
  output logic [3:0]  reg_select,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(NREGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_START,
    S_DATA,
    S_STOP,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  reg_select_q, reg_select_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_nxt;
  logic        baud_wrap;
  logic        csum_sent;
`ifdef REGDUMP_CSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        csum_phase_q, csum_phase_d;

  assign csum_sent = csum_phase_q;
`else
  assign csum_sent = 1'b0;
`endif

  assign cur_byte  = shift_q[31:24];
  assign bit_nxt   = bit_q + 3'd1;
  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d      = state_q;
    reg_select_d = reg_select_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    shift_d      = shift_q;
`ifdef REGDUMP_CSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          reg_select_d = 4'd0;
          busy_d       = 1'b1;
          state_d      = S_SEL;
`ifdef REGDUMP_CSUM_EN
          csum_d       = 8'd0;
          csum_phase_d = 1'b0;
`endif
        end
      end
      S_SEL: begin
        // regval is combinational from reg_select, so it is valid now and captured once.
        shift_d = regval;
        byte_d  = 2'd0;
        bit_d   = 3'd0;
        baud_d  = 16'd0;
        tx_d    = 1'b0;
        state_d = S_START;
`ifdef REGDUMP_CSUM_EN
        csum_d  = csum_q ^ regval[31:24] ^ regval[23:16] ^ regval[15:8] ^ regval[7:0];
`endif
      end
      S_START: begin
        baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
        if (baud_wrap) begin
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
      S_STOP: begin
        baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
        if (baud_wrap) begin
          if (csum_sent) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {shift_q[23:0], 8'h00};
            tx_d    = 1'b0;
            state_d = S_START;
          end else if (reg_select_q < IDX_LAST) begin
            reg_select_d = reg_select_q + 4'd1;
            state_d      = S_SEL;
          end else begin
`ifdef REGDUMP_CSUM_EN
            // Checksum rides the normal byte path; the phase flag routes its STOP to FIN.
            csum_phase_d = 1'b1;
            shift_d      = {csum_q, 24'h000000};
            tx_d         = 1'b0;
            state_d      = S_START;
`else
            done_d  = 1'b1;
            state_d = S_FIN;
`endif
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      reg_select_q <= 4'd0;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      byte_q       <= 2'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef REGDUMP_CSUM_EN
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      reg_select_q <= reg_select_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef REGDUMP_CSUM_EN
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  // Datapath words are always reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef REGDUMP_CSUM_EN
    csum_q  <= csum_d;
`endif
  end

  assign reg_select = reg_select_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regdump_uart_tx.sv
// Bench for regdump_uart_tx: three instances (NREGS=1, 16, 2) at 4 clocks/bit, a UART decoder feeding a byte scoreboard.
`timescale 1ns/1ps
module tb_regdump_uart_tx;
  localparam int CPB     = 4;
  localparam int REG_CYC = 1 + 40 * CPB;
`ifdef REGDUMP_CSUM_EN
  localparam int CSUM_CYC = 10 * CPB;
`else
  localparam int CSUM_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1, start16, start2;
  logic [31:0] regval1, regval16, regval2;
  logic [3:0]  sel1, sel16, sel2;
  logic        tx1, tx16, tx2;
  logic        busy1, busy16, busy2;
  logic        done1, done16, done2;

  always #5 clk = ~clk;

  assign regval16 = {28'h0, sel16};
  assign regval2  = (sel2 == 4'd0) ? 32'hA5A5A5A5 : 32'h0F0F0F0F;

  regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NREGS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .regval(regval1),
    .reg_select(sel1), .tx(tx1), .busy(busy1), .done(done1));
  regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NREGS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .regval(regval16),
    .reg_select(sel16), .tx(tx16), .busy(busy16), .done(done16));
  regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NREGS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .regval(regval2),
    .reg_select(sel2), .tx(tx2), .busy(busy2), .done(done2));

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [1:0] mon_sel = 2'd0;
  logic       mon_tx, mon_busy, mon_done;
  logic [3:0] mon_regsel;

  always_comb begin
    mon_tx     = tx2;
    mon_busy   = busy2;
    mon_done   = done2;
    mon_regsel = sel2;
    case (mon_sel)
      2'd0: begin mon_tx = tx1;  mon_busy = busy1;  mon_done = done1;  mon_regsel = sel1;  end
      2'd1: begin mon_tx = tx16; mon_busy = busy16; mon_done = done16; mon_regsel = sel16; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_csum(input logic [7:0] c);
`ifdef REGDUMP_CSUM_EN
    exp_q.push_back(c);
`else
    if (c === 8'hxx) exp_q.push_back(c);
`endif
  endtask

  task automatic set_start(input logic [1:0] s, input logic v);
    case (s)
      2'd0:    start1  = v;
      2'd1:    start16 = v;
      default: start2  = v;
    endcase
  endtask

  // Serial decoder: samples mid-bit, checks every bit holds for its whole period, pops the scoreboard.
  initial begin : decoder
    int         dt;
    bit         on;
    logic       smp [0:39];
    logic [9:0] bits;
    logic [7:0] rx;
    int         bad;
    on = 1'b0;
    dt = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        on = 1'b0;
      end else begin
        if (!on) begin
          if (mon_tx === 1'b0) begin
            on = 1'b1;
            dt = 0;
          end
        end else begin
          dt++;
        end
        if (on) begin
          smp[dt] = mon_tx;
          if (dt % CPB == CPB / 2) bits[dt / CPB] = mon_tx;
          if (dt == 9 * CPB + CPB / 2) begin
            on = 1'b0;
            rx = bits[8:1];
            bad = 0;
            for (int t = 0; t <= 9 * CPB + CPB / 2; t++)
              if (smp[t] !== bits[t / CPB]) bad++;
            check("bit_shape", bad, 0);
            check("start_bit", bits[0], 1'b0);
            check("stop_bit", bits[9], 1'b1);
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_byte: got %02h required none", rx);
            end else begin
              check("byte", rx, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic run_dump(input logic [1:0] s, input int exp_busy, input int exp_steps, input bit poke);
    int         n, dn, steps, g, bad;
    logic       dl;
    logic [3:0] prev;
    mon_sel = s;
    @(negedge clk);
    set_start(s, 1'b1);
    n = 0; dn = 0; steps = 0; dl = 1'b0; prev = 4'd0;
    for (g = 0; g < 4000; g++) begin
      @(negedge clk);
      if (g == 0) set_start(s, 1'b0);
      if (!mon_busy) break;
      n++;
      if (mon_done) dn++;
      dl = mon_done;
      if (mon_regsel !== prev) begin
        check("sel_step", mon_regsel, prev + 4'd1);
        prev = mon_regsel;
        steps++;
      end
      if (n == 1) begin
        check("sel_tx", mon_tx, 1'b1);
        check("sel_first", mon_regsel, 4'd0);
      end
      if (n == 2) begin
        check("tx_fall", mon_tx, 1'b0);
        if (s == 2'd0) regval1 = $urandom;
      end
      if (poke && n == 700) set_start(s, 1'b1);
      if (poke && n == 702) set_start(s, 1'b0);
    end
    check("dump_timeout", (g >= 4000), 1'b0);
    check("busy_len", n, exp_busy);
    check("done_count", dn, 1);
    check("done_last", dl, 1'b1);
    check("sel_steps", steps, exp_steps);
    check("bytes_left", exp_q.size(), 0);
    bad = 0;
    for (int q = 0; q < 20; q++) begin
      @(negedge clk);
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0 || mon_done !== 1'b0) bad++;
    end
    check("post_quiet", bad, 0);
  endtask

  typedef struct {
    logic [31:0] val;
    logic [7:0]  b0, b1, b2, b3, cs;
  } vec_t;

  vec_t vecs[5];
  int   bad;
  bit   hb;

  initial begin
    vecs[0] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01, 8'h81};
    vecs[4] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};

    start1 = 1'b0; start16 = 1'b0; start2 = 1'b0;
    regval1 = 32'h0;
    mon_sel = 2'd0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_sel", sel1, 4'd0);
    check("rst_tx16", tx16, 1'b1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    for (int v = 0; v < 5; v++) begin
      regval1 = vecs[v].val;
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      exp_q.push_back(vecs[v].b2);
      exp_q.push_back(vecs[v].b3);
      push_csum(vecs[v].cs);
      run_dump(2'd0, REG_CYC + 1 + CSUM_CYC, 0, 1'b0);
    end

    // start held high through FIN restarts on the very first IDLE cycle
    mon_sel = 2'd0;
    regval1 = 32'hCAFEF00D;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
      exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
      push_csum(8'hC9);
    end
    @(negedge clk);
    start1 = 1'b1;
    hb = 1'b0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (busy1) hb = 1'b1;
      else if (hb) break;
    end
    check("held_gap_idle", busy1, 1'b0);
    @(negedge clk);
    check("held_restart", busy1, 1'b1);
    start1 = 1'b0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    check("held_end", busy1, 1'b0);
    check("held_bytes_left", exp_q.size(), 0);

    // async reset during data bit 3 of the second byte
    regval1 = 32'h12345678;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    push_csum(8'h08);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (58) @(negedge clk);
    check("pre_rst_tx", tx1, 1'b0);
    check("pre_rst_busy", busy1, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_tx", tx1, 1'b1);
    check("rst_async_busy", busy1, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("after_rst_idle", busy1, 1'b0);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    push_csum(8'h08);
    run_dump(2'd0, REG_CYC + 1 + CSUM_CYC, 0, 1'b0);

    // full 16-register dump with a stray start mid-dump
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(8'(i));
    end
    push_csum(8'h00);
    run_dump(2'd1, 16 * REG_CYC + 1 + CSUM_CYC, 15, 1'b1);
    check("last_sel16", sel16, 4'd15);

    // two registers whose bytes XOR to zero
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h0F);
    push_csum(8'h00);
    run_dump(2'd2, 2 * REG_CYC + 1 + CSUM_CYC, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/regdump_uart_tx.md
# regdump_uart_tx

Debug register-dump transmitter for the multicycle processor. On a start request it walks the processor's debug register-read port (`reg_select` out, `regval` in) through registers 0..NREGS-1, captures each 32-bit value, and serializes it byte by byte on a UART 8N1 line. It sits beside `processor_top` in the board-level wrapper and is the consumer end of that debug port.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit; legal range 2..65535.
- `NREGS`, default 16: registers dumped, indices 0..NREGS-1; legal range 1..16.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  dump request; sampled only in IDLE.
- `regval`  input  32  register value selected by `reg_select`; combinational from the processor, valid in the same cycle.
- `reg_select`  output  4  register index presented to the processor.
- `tx`  output  1  UART serial line; idles high.
- `busy`  output  1  high from the cycle after `start` is accepted until the cycle `done` pulses, inclusive.
- `done`  output  1  one-cycle pulse after the last stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `reg_select`=0, all counters 0, state IDLE.
- States: IDLE, SEL, START, DATA, STOP, FIN. Checksum states are added only when the macro in Configuration is defined.
- IDLE: when `start`=1, set reg index 0, `busy`=1, go to SEL. In all other states `start` is ignored.
- SEL, one cycle: `reg_select`=index. On exiting SEL, latch `regval` into a 32-bit shift word, set byte count 0, go to START.
- Byte order: most-significant byte first (bits 31:24, then 23:16, 15:8, 7:0). Within a byte, LSB first.
- START: `tx`=0 for CLKS_PER_BIT cycles. DATA: 8 bits, each held CLKS_PER_BIT cycles. STOP: `tx`=1 for CLKS_PER_BIT cycles.
- After STOP:
  - If byte count < 3: increment it and go to START.
  - Else if index < NREGS-1: increment the index and go to SEL.
  - Else: go to FIN.
- FIN, one cycle: `done`=1 and `busy`=1, then IDLE, where `busy`=0.
- `reg_select` holds the last selected index until the next SEL. Its reset value is 0.
- The bit counter is 3 bits, 0..7. The baud counter is 16 bits and counts 0..CLKS_PER_BIT-1, then wraps.

## Timing
- `start` is seen high in IDLE at edge k. SEL is the state from k to k+1, and `tx` falls at edge k+1.
- Per register: 1 SEL cycle plus 4×10×CLKS_PER_BIT cycles.
- Total from `start` accepted to `done`: NREGS×(1+40×CLKS_PER_BIT) cycles, plus 1 FIN cycle. The checksum frame adds 10×CLKS_PER_BIT.
- No idle gap between consecutive bytes of one register. Between registers the gap is exactly one SEL cycle with `tx`=1.
- `regval` must be stable during SEL. A later change to `regval` does not affect the frame in flight.
- `start` held high through FIN is accepted again at the first IDLE cycle.
- `rst` asserted mid-frame forces `tx`=1 and `busy`=0 immediately, without waiting for a clock. The partial frame is abandoned. After release, the block waits in IDLE for a new `start`.

## Configuration
- `REGDUMP_CSUM_EN` defined:
  - After the last register's STOP, one extra 8N1 byte is sent: the XOR of all NREGS×4 data bytes. The accumulator clears on `start` acceptance.
  - `done` follows that byte's stop bit.
- `REGDUMP_CSUM_EN` undefined: no checksum logic or state exists, and `done` follows the last data byte.

## Test plan
- Reset state: CLKS_PER_BIT=4. Assert `rst` for 3 cycles → `tx`=1, `busy`=0, `done`=0, `reg_select`=0. No `tx` edge for 100 cycles with `start`=0.
- Single register: NREGS=1, `regval`=32'h12345678 → bytes 0x12, 0x34, 0x56, 0x78.
  - First byte on `tx` is 0, then 0,1,0,0,1,0,0,0, then 1, each bit 4 cycles.
  - `done` occurs 162 cycles after `start` is accepted.
- Full dump: NREGS=16, `regval`=`{28'h0, reg_select}` → 64 bytes decoded as 00 00 00 00, 00 00 00 01, … 00 00 00 0F.
  - `reg_select` steps 0..15.
  - `busy` stays high for 16×161+1=2577 cycles.
- Start while busy: pulse `start` mid-dump → ignored. Exactly one `done` and the same byte count as a single dump.
- Reset mid-frame: assert `rst` during the DATA bit 3 of the second byte → `tx`=1 before the next clock edge.
  - Next `start` produces a complete, correct dump from register 0.
- Checksum (`REGDUMP_CSUM_EN`): NREGS=2, registers 0xA5A5A5A5 and 0x0F0F0F0F → a ninth byte equal to 0x00.
  - `done` occurs 2×161+40+1=363 cycles after `start`.
